// File: rtl/microtile_pin_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : microtile_pin_arbiter
//  Purpose  : Round-robin time-sharing of one 8-bit ui_in/uo_out pad pair
//             among N_TILES microtile designs, with bounded tenure under
//             contention. Optional turnaround cycle: ARB_TURNAROUND_EN.
//  Revision : 1.0  initial release
// ============================================================================
module microtile_pin_arbiter #(
   parameter int N_TILES     = 4,
   parameter int SLOT_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_TILES-1:0]     req,
   input  logic [7:0]             ui_in,
   input  logic [8*N_TILES-1:0]   tile_uo_out,
   output logic [8*N_TILES-1:0]   tile_ui_in,
   output logic [7:0]             uo_out,
   output logic [N_TILES-1:0]     grant,
   output logic [2:0]             owner,
   output logic                   busy
);

   localparam int                    c_tenure_w   = $clog2(SLOT_CYCLES);
   localparam logic [c_tenure_w-1:0] c_tenure_max = c_tenure_w'(SLOT_CYCLES - 1);
   localparam logic [3:0]            c_n_tiles    = 4'(N_TILES);
   localparam logic [2:0]            c_last_tile  = 3'(N_TILES - 1);
   localparam logic [N_TILES-1:0]    c_one        = N_TILES'(1);

`ifdef ARB_TURNAROUND_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_OWN = 2'd1, S_GAP = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_OWN = 2'd1} state_t;
`endif

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } pick_t;

   // First requester at or after 'start', wrapping modulo N_TILES.
   function automatic pick_t f_arbitrate(input logic [N_TILES-1:0] r,
                                         input logic [2:0]         start);
      pick_t      p;
      logic [7:0] r8;
      logic [3:0] slot;
      p  = '0;
      r8 = '0;
      r8[N_TILES-1:0] = r;
      for (int i = 0; i < N_TILES; i++) begin
         slot = {1'b0, start} + 4'(i);
         if (slot >= c_n_tiles) slot = slot - c_n_tiles;
         if (!p.valid && r8[slot[2:0]]) begin
            p.valid = 1'b1;
            p.idx   = slot[2:0];
         end
      end
      return p;
   endfunction

   state_t                r_state, w_state_nxt;
   logic [N_TILES-1:0]    r_grant, w_grant_nxt;
   logic [2:0]            r_owner, w_owner_nxt;
   logic [2:0]            r_rr_ptr, w_rr_ptr_nxt;
   logic [2:0]            w_owner_inc;
   logic [c_tenure_w-1:0] r_tenure, w_tenure_nxt;
   logic [7:0]            r_uo_out, w_uo_nxt;
   pick_t                 w_pick_ptr;
   logic                  w_exit;

   assign w_owner_inc = (r_owner == c_last_tile) ? 3'd0 : r_owner + 3'd1;
   assign w_pick_ptr  = f_arbitrate(req, r_rr_ptr);

   // Owner released, or slot expired while someone else is waiting.
   assign w_exit = ((req & r_grant) == '0) ||
                   ((r_tenure == c_tenure_max) && ((req & ~r_grant) != '0));

`ifndef ARB_TURNAROUND_EN
   pick_t w_pick_exit;
   // Scanning from owner+1 makes the departing owner the lowest priority.
   assign w_pick_exit = f_arbitrate(req, w_owner_inc);
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_owner_nxt  = r_owner;
      w_rr_ptr_nxt = r_rr_ptr;
      w_tenure_nxt = r_tenure;
      case (r_state)
         S_OWN: begin
            if (w_exit) begin
               w_rr_ptr_nxt = w_owner_inc;
               w_tenure_nxt = '0;
`ifdef ARB_TURNAROUND_EN
               w_state_nxt  = S_GAP;
               w_grant_nxt  = '0;
`else
               if (w_pick_exit.valid) begin
                  w_state_nxt = S_OWN;
                  w_grant_nxt = c_one << w_pick_exit.idx;
                  w_owner_nxt = w_pick_exit.idx;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_grant_nxt = '0;
               end
`endif
            end else if (r_tenure != c_tenure_max) begin
               w_tenure_nxt = r_tenure + 1'b1;
            end
         end
         default: begin
            // IDLE and GAP both arbitrate from rr_ptr; owner keeps last value.
            if (w_pick_ptr.valid) begin
               w_state_nxt  = S_OWN;
               w_grant_nxt  = c_one << w_pick_ptr.idx;
               w_owner_nxt  = w_pick_ptr.idx;
               w_tenure_nxt = '0;
            end else begin
               w_state_nxt  = S_IDLE;
               w_grant_nxt  = '0;
            end
         end
      endcase
   end

   // grant is one-hot or zero, so an OR of gated lanes selects the owner lane.
   always_comb begin
      w_uo_nxt = '0;
      for (int k = 0; k < N_TILES; k++) begin
         if (r_grant[k]) w_uo_nxt = w_uo_nxt | tile_uo_out[8*k +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_owner  <= '0;
         r_rr_ptr <= '0;
         r_tenure <= '0;
         r_uo_out <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_owner  <= w_owner_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_tenure <= w_tenure_nxt;
         r_uo_out <= w_uo_nxt;
      end
   end

   generate
      for (genvar k = 0; k < N_TILES; k++) begin : g_lane
         assign tile_ui_in[8*k +: 8] = r_grant[k] ? ui_in : 8'h00;
      end
   endgenerate

   assign grant  = r_grant;
   assign owner  = r_owner;
   assign busy   = |r_grant;
   assign uo_out = r_uo_out;

endmodule
`default_nettype wire

// File: tb/tb_microtile_pin_arbiter.sv
`default_nettype none
// Testbench for microtile_pin_arbiter: table vectors, corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_microtile_pin_arbiter;

   localparam int N_TILES     = 4;
   localparam int SLOT_CYCLES = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [7:0]  ui_in = '0;
   logic [31:0] tile_uo_out = '0;
   logic [31:0] tile_ui_in;
   logic [7:0]  uo_out;
   logic [3:0]  grant;
   logic [2:0]  owner;
   logic        busy;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // reference model state
   int         m_owner = 0;
   int         m_ptr   = 0;
   int         m_held  = 0;
   bit         m_busy  = 1'b0;
   logic [7:0] m_uo    = '0;

   always #5 clk = ~clk;

   microtile_pin_arbiter #(.N_TILES(N_TILES), .SLOT_CYCLES(SLOT_CYCLES)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .ui_in       (ui_in),
      .tile_uo_out (tile_uo_out),
      .tile_ui_in  (tile_ui_in),
      .uo_out      (uo_out),
      .grant       (grant),
      .owner       (owner),
      .busy        (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      req = '0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk_en = 1'b1;
   endtask

   task automatic model_pick(input logic [3:0] r);
      for (int i = 0; i < N_TILES; i++) begin
         int k;
         k = (m_ptr + i) % N_TILES;
         if (!m_busy && (((r >> k) & 4'b1) != 0)) begin
            m_busy  = 1'b1;
            m_owner = k;
            m_held  = 1;
         end
      end
   endtask

   // m_held counts cycles already spent holding the grant.
   always @(posedge clk) begin
      if (rst) begin
         m_owner = 0; m_ptr = 0; m_held = 0; m_busy = 1'b0; m_uo = '0;
      end else begin
         m_uo = m_busy ? 8'(tile_uo_out >> (8 * m_owner)) : 8'h00;
         if (m_busy) begin
            if ((((req >> m_owner) & 4'b1) == 0) ||
                (m_held >= SLOT_CYCLES && ((req & ~(4'b1 << m_owner)) != 0))) begin
               m_ptr  = (m_owner + 1) % N_TILES;
               m_busy = 1'b0;
`ifndef ARB_TURNAROUND_EN
               model_pick(req);
`endif
            end else if (m_held < SLOT_CYCLES) begin
               m_held++;
            end
         end else begin
            model_pick(req);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("mon_grant", 32'(grant), m_busy ? (32'h1 << m_owner) : 32'h0);
         chk("mon_owner", 32'(owner), 32'(m_owner));
         chk("mon_busy", 32'(busy), 32'(m_busy));
         chk("mon_uo_out", 32'(uo_out), 32'(m_uo));
         chk("mon_tile_ui_in", tile_ui_in, m_busy ? (32'(ui_in) << (8 * m_owner)) : 32'h0);
         chk("inv_onehot0", 32'($onehot0(grant)), 32'h1);
         chk("inv_owner_grant", busy ? 32'((grant >> owner) & 4'b1) : 32'h1, 32'h1);
      end
   end

   typedef struct {
      logic [3:0]  req;
      logic [7:0]  ui;
      logic [31:0] lanes;
      logic [3:0]  exp_grant;
      logic [2:0]  exp_owner;
      logic [7:0]  exp_uo;
      logic [31:0] exp_tui;
   } vec_t;

   vec_t vec[7];

   initial begin
      int bad;
      vec[0] = '{4'b0001, 8'h11, 32'h44332211, 4'b0001, 3'd0, 8'h11, 32'h00000011};
      vec[1] = '{4'b0010, 8'h5A, 32'hDDCCBBAA, 4'b0010, 3'd1, 8'hBB, 32'h00005A00};
      vec[2] = '{4'b0100, 8'h3C, 32'h12A55678, 4'b0100, 3'd2, 8'hA5, 32'h003C0000};
      vec[3] = '{4'b1000, 8'hFF, 32'h9E000000, 4'b1000, 3'd3, 8'h9E, 32'hFF000000};
      vec[4] = '{4'b1010, 8'h81, 32'h01020304, 4'b0010, 3'd1, 8'h03, 32'h00008100};
      vec[5] = '{4'b1100, 8'h7E, 32'hF0E0D0C0, 4'b0100, 3'd2, 8'hE0, 32'h007E0000};
      vec[6] = '{4'b1111, 8'h00, 32'h00000099, 4'b0001, 3'd0, 8'h99, 32'h00000000};

      for (int i = 0; i < 7; i++) begin
         do_reset();
         req = vec[i].req; ui_in = vec[i].ui; tile_uo_out = vec[i].lanes;
         tick(1);
         chk("vec_grant", 32'(grant), 32'(vec[i].exp_grant));
         chk("vec_owner", 32'(owner), 32'(vec[i].exp_owner));
         chk("vec_busy", 32'(busy), 32'h1);
         chk("vec_tile_ui_in", tile_ui_in, vec[i].exp_tui);
         tick(1);
         chk("vec_uo_out", 32'(uo_out), 32'(vec[i].exp_uo));
      end

      // reset during an active grant to tile 2
      do_reset();
      req = 4'b0100; tile_uo_out = 32'h00A50000;
      tick(2);
      chk("rst_pre_grant", 32'(grant), 32'h4);
      rst = 1'b1;
      tick(1);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);
      chk("rst_uo_out", 32'(uo_out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0; req = 4'b1010;
      tick(1);
      chk("rst_first_winner", 32'(grant), 32'h2);

      // contention rotation
      do_reset();
      req = 4'b1111;
      tick(1);
      for (int t = 0; t < 4; t++) begin
         int run;
         run = 0;
         while (grant === 4'(1 << t) && run < 100) begin
            run++;
            tick(1);
         end
         chk("rotation_len", 32'(run), 32'(SLOT_CYCLES));
`ifdef ARB_TURNAROUND_EN
         chk("rotation_gap", 32'(grant), 32'h0);
         tick(1);
`endif
      end
      chk("rotation_wrap", 32'(grant), 32'h1);

      // no-competitor saturation, then a late competitor
      do_reset();
      req = 4'b0001;
      tick(1);
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         if (grant !== 4'b0001) bad++;
         tick(1);
      end
      chk("sat_hold_bad_cycles", 32'(bad), 32'h0);
      req = 4'b0101;
      tick(1);
`ifdef ARB_TURNAROUND_EN
      chk("sat_gap", 32'(grant), 32'h0);
      tick(1);
`endif
      chk("sat_handover", 32'(grant), 32'h4);

      // early release by tile 3 at tenure 5
      do_reset();
      req = 4'b1000;
      tick(1);
      chk("early_own3", 32'(grant), 32'h8);
      req = 4'b1001;
      tick(5);
      chk("early_hold", 32'(grant), 32'h8);
      req = 4'b0001;
      tick(1);
`ifdef ARB_TURNAROUND_EN
      chk("early_gap", 32'(grant), 32'h0);
      tick(1);
`endif
      chk("early_handover", 32'(grant), 32'h1);
      chk("early_owner", 32'(owner), 32'h0);

      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) req = 4'($urandom);
         ui_in       = 8'($urandom);
         tile_uo_out = $urandom;
         rst         = ($urandom_range(0, 99) == 0);
         tick(1);
      end
      rst = 1'b0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/microtile_pin_arbiter.md
# microtile_pin_arbiter

Time-shares the single 8-bit `ui_in`/`uo_out` pad pair of a microtile slot between up to eight internal microtile designs. Requesters raise `req`. A round-robin scheduler grants exactly one tile at a time. The owner has a bounded tenure that is enforced only under contention. The block sits between the tile top-level pins and the per-design cores. It gates the input bus to the owner and registers the owner's output bus onto `uo_out`.

## Interface
- `N_TILES`, default 4: number of requesting tiles; legal range 2..8.
- `SLOT_CYCLES`, default 16: maximum tenure, in cycles, when another tile is waiting; legal minimum 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  N_TILES  per-tile ownership request; level-sensitive.
- `ui_in`  in  8  pad input bus.
- `tile_uo_out`  in  8*N_TILES  per-tile output buses; tile k occupies bits [8k+7:8k].
- `tile_ui_in`  out  8*N_TILES  per-tile input buses; the owner's lane carries `ui_in`, all other lanes are 0.
- `uo_out`  out  8  registered copy of the owner's output lane.
- `grant`  out  N_TILES  one-hot or zero; registered.
- `owner`  out  3  index of the current owner; holds the last owner while nobody is granted.
- `busy`  out  1  high while `grant` is nonzero.

## Operation
- States:
  - IDLE: no grant.
  - OWN: `grant[owner]`=1.
  - GAP: turnaround; exists only with the macro defined.
- Arbitration picks the first `req` bit scanning from `rr_ptr` upward, wrapping modulo N_TILES.
  - `rr_ptr` resets to 0.
  - On every exit from OWN, `rr_ptr` <= (owner+1) mod N_TILES.
- IDLE -> OWN when any `req` is high. The winner is registered into `grant`/`owner`, and `tenure` is cleared to 0.
- In OWN, `tenure` increments each cycle and saturates at SLOT_CYCLES-1. Width is clog2(SLOT_CYCLES).
- OWN exit conditions:
  - (a) `req[owner]` is low.
  - (b) `tenure`==SLOT_CYCLES-1 while any other `req` bit is high.
- At tenure limit with no competitor, ownership continues indefinitely with `tenure` held saturated.
- On exit, the next state is GAP when the macro is defined, otherwise a direct handoff (see Configuration).
- `tile_ui_in` is combinational from registered `grant` and live `ui_in`. When nobody is granted, all lanes are 0.
- `uo_out` <= `busy` ? `tile_uo_out[owner lane]` : 0. This is registered, one cycle behind `grant`.
- Reset values: `grant`=0, `owner`=0, `busy`=0, `uo_out`=0, `rr_ptr`=0, `tenure`=0, state IDLE.
- Reset asserted mid-tenure or mid-GAP returns everything to reset values at that edge. No grant may survive it.
- Simultaneous requests are resolved by round-robin order only. A request arriving in the same cycle the owner releases competes normally.

## Timing
- Grant latency: `req[k]` high before edge n -> `grant[k]`=1 after edge n.
- `uo_out` reflects tile k from edge n+1.
- Release latency: `req[owner]` low before edge m -> `grant` deasserts/changes after edge m; `uo_out` follows at m+1.
- Under contention, the owner holds `grant` for exactly SLOT_CYCLES consecutive cycles.
- Handoff, macro undefined: one edge. The old grant drops and the new grant rises at the same edge. `grant` is never two-hot.

## Configuration
- `ARB_TURNAROUND_EN`
- Defined:
  - Every exit from OWN enters GAP for exactly one cycle, with `grant`=0, `busy`=0 and `uo_out` forced to 0 in the following cycle.
  - GAP performs arbitration and goes to OWN (winner) or IDLE (no request).
  - Handoff costs 2 edges.
- Undefined:
  - GAP does not exist.
  - On exit, arbitration runs in the same cycle, with the exiting owner lowest priority. The next state is OWN with the new winner, or IDLE if none.
  - A continuing owner re-winning after a timeout is impossible, because a competitor exists by definition.

## Test plan
- Reset: assert `rst` during an active grant to tile 2 -> next edge `grant`=0, `owner`=0, `uo_out`=0, `busy`=0. First request after reset from tiles 1 and 3 together -> tile 1 wins.
- Single requester: `req`=0b0100, `tile_uo_out` lane2=8'hA5, `ui_in`=8'h3C.
  - `grant`=0b0100 one edge later; `uo_out`=8'hA5 one edge after that.
  - Lane2 of `tile_ui_in` =8'h3C; other lanes 0.
- Contention rotation: `req`=0b1111 held, SLOT_CYCLES=16 -> owners 0,1,2,3,0 in turn, each granted exactly 16 cycles.
  - Plus one GAP cycle between owners when `ARB_TURNAROUND_EN` is defined.
- No-competitor saturation: `req`=0b0001 held for 100 cycles -> `grant` stays 0b0001 throughout. Raising `req[2]` at cycle 100 hands over after exactly 1 cycle.
- Early release: tile 3 owns and drops `req[3]` at tenure 5 while `req[0]`=1 -> grant moves to tile 0 (after GAP if defined) and `rr_ptr`=0.
- Invariant check all tests: `grant` is always zero or one-hot; `owner` is consistent with `grant` while `busy`=1.
